vram_dma: RTL and testbench
===========================

// Module: vram_dma
// PURPOSE
//  Owns the CPU-side VRAM port and shares it between CPU accesses and a block-copy DMA engine.
//  The DMA streams words from main memory into sprite/map/tile/palette VRAM (0x0600_0000-0x063F_FFFF),
//  optionally only during vblank. It sits between the CPU bus fabric and vram's mem_* port, and raises irq on completion.
// PARAMETERS
//  FIFO_DEPTH  4   source-data buffer depth in words (power of 2, >=2)
//  STARVE_MAX  8   consecutive denied DMA cycles before DMA is forced one VRAM slot
//  ADDR_INC    4   src/dst address increment per word
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  cfg_en       in   1   register access strobe
//  cfg_we       in   1   register write
//  cfg_addr     in   2   0:SRC 1:DST 2:LEN 3:CTRL/STATUS
//  cfg_din      in   32  register write data
//  cfg_dout     out  32  register read data, combinational from cfg_addr
//  cpu_en       in   1   CPU VRAM access request
//  cpu_we       in   1   CPU VRAM write
//  cpu_addr     in   32  CPU VRAM address
//  cpu_din      in   32  CPU VRAM write data
//  cpu_dout     out  32  CPU read data, valid the cycle after an accepted read
//  cpu_stall    out  1   CPU access not accepted this cycle; CPU holds request
//  src_req      out  1   main-memory read request
//  src_addr     out  32  main-memory read address
//  src_gnt      in   1   request accepted
//  src_rvalid   in   1   read data valid, in request order, latency >=1
//  src_rdata    in   32  read data
//  vram_en      out  1   to vram mem_en
//  vram_we      out  1   to vram mem_we
//  vram_addr    out  32  to vram mem_addr
//  vram_din     out  32  to vram mem_din
//  vram_dout    in   32  from vram mem_dout
//  vblank       in   1   vertical blank level from VPU timing
//  irq          out  1   level; done & irq_en
// BEHAVIOUR
//  Reset: all outputs 0; SRC/DST/LEN/CTRL 0; FSM IDLE; FIFO empty; starve counter 0.
//  CTRL write: b0 start, b1 vbl_only, b2 irq_en, b3 abort, b9 write-1-clears done.
//  CTRL read: b1, b2, b8 busy, b9 done. SRC/DST/LEN (LEN[15:0], in words) writes ignored while busy.
//  FSM: IDLE -start-> RUN (LEN=0: set done, stay IDLE, no accesses).
//    RUN -> last word written -> IDLE, done=1.
//    RUN -abort-> FLUSH -> outstanding==0 -> IDLE; FIFO cleared, done not set.
//  Fetch: src_req asserted while fetched words < LEN and fifo_count+outstanding < FIFO_DEPTH.
//    src_req and src_addr held stable until src_gnt. src_addr += ADDR_INC per grant.
//    src_rvalid pushes src_rdata into the FIFO (dropped in FLUSH). outstanding counter is 3 bits min.
//  VRAM slot per cycle:
//    - CPU wins when cpu_en.
//    - DMA write (pop FIFO, vram_we=1, dst += ADDR_INC) when FIFO non-empty, not paused and CPU idle.
//    - Starvation: DMA pending and denied STARVE_MAX cycles -> next cycle DMA takes slot, cpu_stall=1, counter clears.
//    - Pause: vbl_only & !vblank. Fetching continues until FIFO is full; writes resume when vblank rises.
//  vram_* is a combinational mux of the winner; cpu_stall is combinational. cpu_dout = vram_dout (1-cycle read latency).
//  Simultaneous events:
//    - Same-cycle FIFO push and pop keeps count.
//    - Abort and completion in the same cycle: completion wins.
//    - Start while busy is ignored.
//  Reset mid-transfer: immediate return to reset state. In-flight src_rvalid after reset is ignored by the bench.
//  DST is not range-checked; vram decodes.
// STRUCTURE
//  gameconsole_pkg:
//    - dma_state_t {IDLE, RUN, FLUSH}
//    - DMA_REG_SRC/DST/LEN/CTRL offsets
//    - CTRL bit indices
//    - VRAM_BASE=32'h0600_0000
//  Sub-module sync_fifo #(DEPTH, DATA_W=32): push/pop/clear, count, full/empty.
//  Remaining arbitration, FSM and counters stay inline.
// TESTING
//  1. SRC=0x100, DST=0x0620_0000, LEN=4, start, CPU idle, src latency 2 ->
//     4 VRAM writes to 0x0620_0000..0x0620_000C with source data; done=1, busy=0.
//  2. Same as 1 with cpu_en held continuously -> cpu_stall pulses once every STARVE_MAX+1=9 cycles;
//     each pulse is a DMA write; all 4 words land.
//  3. vbl_only=1, vblank=0, LEN=8 -> exactly FIFO_DEPTH=4 fetches, zero VRAM writes;
//     raise vblank -> remaining writes; done.
//  4. Abort after 2 writes with 3 reads outstanding -> busy until 3rd rvalid, no further VRAM writes, done=0.
//  5. LEN=0 start -> done=1 next cycle, no src_req/vram_en; irq=1 if irq_en; W1C done -> irq=0.
//  6. rst_n low mid-transfer -> all outputs 0 asynchronously; registers 0 after release.

Source files
------------

// File: rtl/gameconsole_pkg.sv
// Shared types and constants for the VRAM DMA engine and its register map.
package gameconsole_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } dma_state_t;

    localparam logic [1:0] DMA_REG_SRC  = 2'd0;
    localparam logic [1:0] DMA_REG_DST  = 2'd1;
    localparam logic [1:0] DMA_REG_LEN  = 2'd2;
    localparam logic [1:0] DMA_REG_CTRL = 2'd3;

    localparam int CTRL_START    = 0;
    localparam int CTRL_VBL_ONLY = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_ABORT    = 3;
    localparam int CTRL_BUSY     = 8;
    localparam int CTRL_DONE     = 9;

    localparam logic [31:0] VRAM_BASE = 32'h0600_0000;

endpackage

// File: rtl/vram_dma_fifo.sv
// Synchronous FIFO buffering DMA source words ahead of their VRAM slot.
module sync_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/vram_dma.sv
// VRAM port owner: arbitrates CPU accesses against a main-memory-to-VRAM block-copy DMA.
module vram_dma
    import gameconsole_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8,
    parameter int ADDR_INC   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_en,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_din,
    output logic [31:0] cfg_dout,
    input  logic        cpu_en,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_din,
    output logic [31:0] cpu_dout,
    output logic        cpu_stall,
    output logic        src_req,
    output logic [31:0] src_addr,
    input  logic        src_gnt,
    input  logic        src_rvalid,
    input  logic [31:0] src_rdata,
    output logic        vram_en,
    output logic        vram_we,
    output logic [31:0] vram_addr,
    output logic [31:0] vram_din,
    input  logic [31:0] vram_dout,
    input  logic        vblank,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = ($clog2(FIFO_DEPTH + 1) > 3) ? $clog2(FIFO_DEPTH + 1) : 3;
    localparam int SW = $clog2(STARVE_MAX + 1);

    dma_state_t state, state_next;

    logic [31:0]   src_reg, dst_reg, src_ptr, dst_ptr;
    logic [15:0]   len_reg, fetched, written;
    logic          vbl_only, irq_en, done, finish;
    logic [OW-1:0] outstanding;
    logic [SW-1:0] starve_cnt;

    logic [31:0]   fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty, fifo_push;

    logic cfg_wr, ctrl_wr, start_req, abort_req, start_ok, busy;
    logic grant, rv_ok, dma_pending, starve_force, dma_win, last_write;

    assign cfg_wr    = cfg_en && cfg_we;
    assign ctrl_wr   = cfg_wr && (cfg_addr == DMA_REG_CTRL);
    assign start_req = ctrl_wr && cfg_din[CTRL_START];
    assign abort_req = ctrl_wr && cfg_din[CTRL_ABORT];
    assign busy      = (state != IDLE);
    assign start_ok  = start_req && (state == IDLE);

    // Budget counts words already buffered plus words still in flight, so grants never overrun the FIFO.
    assign src_req  = (state == RUN) && (fetched < len_reg) &&
                      ((32'(fifo_count) + 32'(outstanding)) < 32'(FIFO_DEPTH));
    assign src_addr = src_ptr;
    assign grant    = src_req && src_gnt;
    assign rv_ok    = src_rvalid && (outstanding != '0);
    assign fifo_push = rv_ok && (state == RUN) && !fifo_full;

    assign dma_pending  = (state == RUN) && !fifo_empty && !(vbl_only && !vblank);
    assign starve_force = dma_pending && (starve_cnt == SW'(STARVE_MAX));
    assign dma_win      = dma_pending && (!cpu_en || starve_force);
    assign last_write   = dma_win && ((written + 16'd1) == len_reg);

    assign cpu_stall = cpu_en && dma_win;
    assign vram_en   = cpu_en || dma_win;
    assign vram_we   = dma_win ? 1'b1 : (cpu_en && cpu_we);
    assign vram_addr = dma_win ? dst_ptr : (cpu_en ? cpu_addr : '0);
    assign vram_din  = dma_win ? fifo_dout : (cpu_en ? cpu_din : '0);
    assign cpu_dout  = vram_dout;
    assign irq       = done && irq_en;

    sync_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == FLUSH),
        .push  (fifo_push),
        .din   (src_rdata),
        .pop   (dma_win),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Completion is tested before abort so a final write in the abort cycle still finishes the job.
    always_comb begin
        state_next = state;
        finish     = 1'b0;
        case (state)
            IDLE:  if (start_ok && (len_reg != '0)) state_next = RUN;
            RUN: begin
                if (last_write) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end else if (abort_req) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: if (outstanding == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_reg     <= '0;
            dst_reg     <= '0;
            len_reg     <= '0;
            vbl_only    <= 1'b0;
            irq_en      <= 1'b0;
            done        <= 1'b0;
            src_ptr     <= '0;
            dst_ptr     <= '0;
            fetched     <= '0;
            written     <= '0;
            outstanding <= '0;
            starve_cnt  <= '0;
        end else begin
            if (cfg_wr && !busy) begin
                case (cfg_addr)
                    DMA_REG_SRC: src_reg <= cfg_din;
                    DMA_REG_DST: dst_reg <= cfg_din;
                    DMA_REG_LEN: len_reg <= cfg_din[15:0];
                    default: ;
                endcase
            end
            if (ctrl_wr) begin
                vbl_only <= cfg_din[CTRL_VBL_ONLY];
                irq_en   <= cfg_din[CTRL_IRQ_EN];
            end
            if (start_ok) begin
                src_ptr <= src_reg;
                dst_ptr <= dst_reg;
                fetched <= '0;
                written <= '0;
                done    <= (len_reg == '0);
            end else begin
                if (grant) begin
                    src_ptr <= src_ptr + 32'(ADDR_INC);
                    fetched <= fetched + 16'd1;
                end
                if (dma_win) begin
                    dst_ptr <= dst_ptr + 32'(ADDR_INC);
                    written <= written + 16'd1;
                end
                if (finish)                            done <= 1'b1;
                else if (ctrl_wr && cfg_din[CTRL_DONE]) done <= 1'b0;
            end
            case ({grant, rv_ok})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
            if (dma_win || !dma_pending) starve_cnt <= '0;
            else                         starve_cnt <= starve_cnt + SW'(1);
        end
    end

    always_comb begin
        cfg_dout = '0;
        case (cfg_addr)
            DMA_REG_SRC: cfg_dout = src_reg;
            DMA_REG_DST: cfg_dout = dst_reg;
            DMA_REG_LEN: cfg_dout = {16'h0000, len_reg};
            default: begin
                cfg_dout[CTRL_VBL_ONLY] = vbl_only;
                cfg_dout[CTRL_IRQ_EN]   = irq_en;
                cfg_dout[CTRL_BUSY]     = busy;
                cfg_dout[CTRL_DONE]     = done;
            end
        endcase
    end

endmodule

// File: tb/tb_vram_dma.sv
// Directed bench for vram_dma with a budgeted main-memory responder and VRAM write monitor.
module tb_vram_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_en = 1'b0, cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [31:0] cfg_din = '0, cfg_dout;
    logic        cpu_en = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_din = '0, cpu_dout;
    logic        cpu_stall;
    logic        src_req, src_gnt = 1'b0, src_rvalid = 1'b0;
    logic [31:0] src_addr, src_rdata = '0;
    logic        vram_en, vram_we;
    logic [31:0] vram_addr, vram_din;
    logic [31:0] vram_dout = 32'h0;
    logic        vblank = 1'b0;
    logic        irq;

    vram_dma #(
        .FIFO_DEPTH (4),
        .STARVE_MAX (8),
        .ADDR_INC   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_en     (cfg_en),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_din    (cfg_din),
        .cfg_dout   (cfg_dout),
        .cpu_en     (cpu_en),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .cpu_stall  (cpu_stall),
        .src_req    (src_req),
        .src_addr   (src_addr),
        .src_gnt    (src_gnt),
        .src_rvalid (src_rvalid),
        .src_rdata  (src_rdata),
        .vram_en    (vram_en),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_din   (vram_din),
        .vram_dout  (vram_dout),
        .vblank     (vblank),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int lat = 2;
    int gnt_limit = 1 << 30, rv_limit = 1 << 30;
    int grants_total = 0, rv_total = 0, req_cycles = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [31:0] wr_addr_q[$], wr_data_q[$];
    int          stall_q[$];

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a * 32'd3 + 32'h1000_0000;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Main-memory responder: grants and returns data within limits set by the main sequence.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n) begin
                q_addr.delete();
                q_due.delete();
                src_gnt    = 1'b0;
                src_rvalid = 1'b0;
                src_rdata  = '0;
            end else begin
                src_gnt = src_req && (grants_total < gnt_limit);
                if (src_gnt) begin
                    grants_total++;
                    q_addr.push_back(src_addr);
                    q_due.push_back(cyc + lat);
                end
                src_rvalid = 1'b0;
                src_rdata  = '0;
                if (q_due.size() > 0 && q_due[0] <= cyc && rv_total < rv_limit) begin
                    src_rvalid = 1'b1;
                    src_rdata  = data_of(q_addr[0]);
                    void'(q_addr.pop_front());
                    void'(q_due.pop_front());
                    rv_total++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (vram_en && vram_we) begin
                    wr_addr_q.push_back(vram_addr);
                    wr_data_q.push_back(vram_din);
                end
                if (cpu_stall) stall_q.push_back(cyc);
                if (src_req) req_cycles++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_en = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_din = d;
        step(1);
        cfg_en = 1'b0; cfg_we = 1'b0; cfg_din = '0;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
        cfg_addr = a; cfg_en = 1'b1; cfg_we = 1'b0;
        #1;
        d = cfg_dout;
        cfg_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        logic [31:0] c;
        int n;
        n = 0;
        cfg_read(2'd3, c);
        while (c[8] && n < max_cyc) begin
            step(1);
            cfg_read(2'd3, c);
            n++;
        end
        check_val(tag, {31'd0, c[8]}, 32'd0);
    endtask

    task automatic check_writes(input string tag, input int base, input int cnt,
                                input logic [31:0] src, input logic [31:0] dst);
        check_val({tag, "_count"}, 32'(wr_addr_q.size() - base), 32'(cnt));
        for (int k = 0; k < cnt; k++) begin
            if (base + k < wr_addr_q.size()) begin
                check_val({tag, "_addr"}, wr_addr_q[base + k], dst + 32'(4 * k));
                check_val({tag, "_data"}, wr_data_q[base + k], data_of(src + 32'(4 * k)));
            end
        end
    endtask

    initial begin
        logic [31:0] r;
        int wb, sb, gb, rb, qb;

        step(3);
        rst_n = 1'b1;
        step(1);
        for (int a = 0; a < 4; a++) begin
            cfg_read(2'(a), r);
            check_val("reset_reg", r, 32'd0);
        end
        check_val("reset_outs", {27'd0, src_req, vram_en, vram_we, cpu_stall, irq}, 32'd0);

        // 1: plain copy, CPU idle
        lat = 2;
        wb = wr_addr_q.size();
        cfg_write(2'd0, 32'h0000_0100);
        cfg_write(2'd1, 32'h0620_0000);
        cfg_write(2'd2, 32'd4);
        cfg_write(2'd3, 32'h1);
        wait_idle("t1_idle", 200);
        check_writes("t1", wb, 4, 32'h0000_0100, 32'h0620_0000);
        cfg_read(2'd3, r);
        check_val("t1_done", r & 32'h300, 32'h200);

        // 2: CPU hogs the port; DMA only gets starvation slots
        wb = wr_addr_q.size();
        sb = stall_q.size();
        cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0600_0040;
        cfg_write(2'd0, 32'h0000_0200);
        cfg_write(2'd1, 32'h0620_0100);
        cfg_write(2'd3, 32'h1);
        wait_idle("t2_idle", 300);
        cpu_en = 1'b0;
        check_writes("t2", wb, 4, 32'h0000_0200, 32'h0620_0100);
        check_val("t2_stalls", 32'(stall_q.size() - sb), 32'd4);
        for (int i = 1; i < 4; i++)
            if (sb + i < stall_q.size())
                check_val("t2_interval", 32'(stall_q[sb + i] - stall_q[sb + i - 1]), 32'd9);

        // 3: vblank-only transfer pauses writes while fetch fills the FIFO
        wb = wr_addr_q.size();
        gb = grants_total;
        vblank = 1'b0;
        cfg_write(2'd0, 32'h0000_0400);
        cfg_write(2'd1, 32'h0630_0000);
        cfg_write(2'd2, 32'd8);
        cfg_write(2'd3, 32'h3);
        step(30);
        check_val("t3_fetches", 32'(grants_total - gb), 32'd4);
        check_val("t3_no_writes", 32'(wr_addr_q.size() - wb), 32'd0);
        cfg_write(2'd2, 32'd5);
        cfg_read(2'd2, r);
        check_val("t3_len_locked", r, 32'd8);
        cfg_read(2'd3, r);
        check_val("t3_ctrl_busy", r & 32'h302, 32'h102);
        vblank = 1'b1;
        wait_idle("t3_idle", 300);
        check_writes("t3", wb, 8, 32'h0000_0400, 32'h0630_0000);
        vblank = 1'b0;

        // 4: abort with three reads still in flight
        lat = 1;
        wb = wr_addr_q.size();
        gb = grants_total;
        rb = rv_total;
        gnt_limit = gb + 5;
        rv_limit  = rb;
        cfg_write(2'd0, 32'h0000_0800);
        cfg_write(2'd1, 32'h0610_0000);
        cfg_write(2'd3, 32'h200 | 32'h1);
        step(10);
        rv_limit = rb + 2;
        step(10);
        check_val("t4_pre_writes", 32'(wr_addr_q.size() - wb), 32'd2);
        check_val("t4_grants", 32'(grants_total - gb), 32'd5);
        qb = wr_addr_q.size();
        cfg_write(2'd3, 32'h8);
        step(5);
        cfg_read(2'd3, r);
        check_val("t4_busy_flush", {31'd0, r[8]}, 32'd1);
        rv_limit = rb + 5;
        step(8);
        cfg_read(2'd3, r);
        check_val("t4_idle", {31'd0, r[8]}, 32'd0);
        check_val("t4_done", {31'd0, r[9]}, 32'd0);
        check_val("t4_post_writes", 32'(wr_addr_q.size() - qb), 32'd0);
        gnt_limit = 1 << 30;
        rv_limit  = 1 << 30;

        // 5: zero-length transfer and interrupt
        cfg_write(2'd2, 32'd0);
        cfg_write(2'd3, 32'h204);
        check_val("t5_irq_pre", {31'd0, irq}, 32'd0);
        wb = wr_addr_q.size();
        rb = req_cycles;
        cfg_write(2'd3, 32'h5);
        cfg_read(2'd3, r);
        check_val("t5_done", r & 32'h300, 32'h200);
        check_val("t5_irq", {31'd0, irq}, 32'd1);
        step(3);
        check_val("t5_no_req", 32'(req_cycles - rb), 32'd0);
        check_val("t5_no_write", 32'(wr_addr_q.size() - wb), 32'd0);
        cfg_write(2'd3, 32'h204);
        check_val("t5_irq_clr", {31'd0, irq}, 32'd0);

        // 6: asynchronous reset in the middle of a transfer
        lat = 2;
        cfg_write(2'd0, 32'h0000_1000);
        cfg_write(2'd1, 32'h0620_0200);
        cfg_write(2'd2, 32'd8);
        cfg_write(2'd3, 32'h5);
        step(6);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("t6_outs", {27'd0, src_req, vram_en, vram_we, cpu_stall, irq}, 32'd0);
        check_val("t6_vram_bus", vram_addr | vram_din | src_addr, 32'd0);
        step(3);
        rst_n = 1'b1;
        step(1);
        for (int a = 0; a < 4; a++) begin
            cfg_read(2'(a), r);
            check_val("t6_reg", r, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
